// File: rtl/morse_sequencer.sv
// Morse keyer: plays letters A-H on led, one UNIT_CYCLES time unit per dot.
// Define MORSE_TRAILING_GAP_EN to add a 3-unit TAIL gap before the done pulse.
module morse_sequencer #(
  parameter int UNIT_CYCLES = 25000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic [2:0] letter,
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  localparam int TW = 30;
  localparam logic [TW-1:0] UNIT_M1 = TW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0] DASH_M1 = TW'(3 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYM  = 3'd1,
    GAP  = 3'd2,
    TAIL = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      pat_q, pat_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      tbl_pat;
  logic [2:0]      tbl_len;

  // Timer holds remaining cycles minus one, so a load of N-1 gives N cycles.
  function automatic logic [TW-1:0] sym_time(input logic dash);
    return dash ? DASH_M1 : UNIT_M1;
  endfunction

  // Pattern is MSB-first, left-justified: 0=dot, 1=dash.
  always_comb begin
    tbl_pat = 4'b0000;
    tbl_len = 3'd1;
    case (letter)
      3'd0: begin tbl_pat = 4'b0100; tbl_len = 3'd2; end
      3'd1: begin tbl_pat = 4'b1000; tbl_len = 3'd4; end
      3'd2: begin tbl_pat = 4'b1010; tbl_len = 3'd4; end
      3'd3: begin tbl_pat = 4'b1000; tbl_len = 3'd3; end
      3'd4: begin tbl_pat = 4'b0000; tbl_len = 3'd1; end
      3'd5: begin tbl_pat = 4'b0010; tbl_len = 3'd4; end
      3'd6: begin tbl_pat = 4'b1100; tbl_len = 3'd3; end
      default: begin tbl_pat = 4'b0000; tbl_len = 3'd4; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SYM;
          pat_d   = tbl_pat;
          cnt_d   = tbl_len;
          timer_d = sym_time(tbl_pat[3]);
        end
      end
      SYM: begin
        if (timer_q == '0) begin
          if (cnt_q > 3'd1) begin
            state_d = GAP;
            timer_d = UNIT_M1;
          end else begin
`ifdef MORSE_TRAILING_GAP_EN
            state_d = TAIL;
            timer_d = DASH_M1;
`else
            state_d = DONE;
`endif
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          state_d = SYM;
          pat_d   = {pat_q[2:0], 1'b0};
          cnt_d   = cnt_q - 3'd1;
          timer_d = sym_time(pat_q[2]);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`ifdef MORSE_TRAILING_GAP_EN
      TAIL: begin
        if (timer_q == '0) state_d = DONE;
        else               timer_d = timer_q - 1'b1;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign led   = (state_q == SYM);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with UNIT_CYCLES=4; per-cycle expectations
// {led,busy,done,state} are queued at stimulus time and popped each cycle.
module tb_morse_sequencer;
  localparam int U = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       start;
  logic [2:0] letter;
  logic       led, busy, done;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];
  string code[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  localparam logic [5:0] E_IDLE = {3'b000, 3'd0};
  localparam logic [5:0] E_SYM  = {3'b110, 3'd1};
  localparam logic [5:0] E_GAP  = {3'b010, 3'd2};
  localparam logic [5:0] E_TAIL = {3'b010, 3'd3};
  localparam logic [5:0] E_DONE = {3'b011, 3'd4};

  morse_sequencer #(.UNIT_CYCLES(U)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .start (start),
    .letter(letter),
    .led   (led),
    .busy  (busy),
    .done  (done),
    .state (state)
  );

  always #5 Clock = ~Clock;

  task automatic push_n(input int n, input logic [5:0] v);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic push_letter(input int l);
    string s;
    byte   c;
    s = code[l];
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      push_n((c == 8'h2d) ? 3 * U : U, E_SYM);
      if (i < s.len() - 1) push_n(U, E_GAP);
    end
`ifdef MORSE_TRAILING_GAP_EN
    push_n(3 * U, E_TAIL);
`endif
    push_n(1, E_DONE);
  endtask

  task automatic step(input string tag);
    logic [5:0] obs, expv;
    @(negedge Clock);
    obs = {led, busy, done, state};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: scoreboard empty, observed=%b required=<entry>", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        n_bad++;
        $error("FAIL %s: led/busy/done/state observed=%b required=%b", tag, obs, expv);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step(tag);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; letter = 3'd0;
    push_n(2, E_IDLE);
    step("reset_hold");
    step("reset_hold");
    Reset = 1'b0;
    push_n(1, E_IDLE);
    step("reset_release");

    // Every letter of the table, back to back.
    for (int l = 0; l < 8; l++) begin
      start = 1'b1; letter = 3'(l);
      push_letter(l);
      push_n(1, E_IDLE);
      @(posedge Clock); #1 start = 1'b0;
      drain($sformatf("letter_%0d", l));
    end

    // H with a second start and letter change mid-letter.
    start = 1'b1; letter = 3'd7;
    push_letter(7);
    push_n(1, E_IDLE);
    @(posedge Clock); #1 start = 1'b0;
    for (int k = 1; k <= 5; k++) step("H_repulse");
    start = 1'b1; letter = 3'd0;
    step("H_repulse");
    start = 1'b0; letter = 3'd3;
    drain("H_repulse");

    // Start held through DONE: ignored in DONE, accepted in the following IDLE.
    start = 1'b1; letter = 3'd4;
    push_letter(4);
    push_n(1, E_IDLE);
    @(posedge Clock); #1 start = 1'b0;
    for (int k = 1; k <= 5; k++) step("done_restart");
    start = 1'b1; letter = 3'd6;
    push_letter(6);
    push_n(1, E_IDLE);
    step("done_restart");
    @(posedge Clock); #1 start = 1'b0;
    drain("done_restart");

    // B aborted by reset: no done pulse afterwards.
    start = 1'b1; letter = 3'd1;
    push_letter(1);
    while (exp_q.size() > 10) void'(exp_q.pop_back());
    @(posedge Clock); #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) step("B_abort");
    Reset = 1'b1;
    push_n(41, E_IDLE);
    step("B_abort_reset");
    Reset = 1'b0;
    drain("B_abort_idle");

    // Reset and start together: start discarded.
    Reset = 1'b1; start = 1'b1; letter = 3'd7;
    push_n(1, E_IDLE);
    step("reset_start");
    Reset = 1'b0; start = 1'b0;
    push_n(3, E_IDLE);
    drain("reset_start_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 Parameter: UNIT_CYCLES, default 25000000, clock cycles per Morse time unit (0.5 s at 50 MHz); legal range 1 to 2^28.
REQ-002 Port: Clock  input  1  sole clock, rising-edge active.
REQ-003 Port: Reset  input  1  synchronous, active-high reset; takes priority over every other input.
REQ-004 Port: start  input  1  request pulse; sampled on each rising Clock edge.
REQ-005 Port: letter  input  3  letter select sampled with start: 0=A .-, 1=B -..., 2=C -.-., 3=D -.., 4=E ., 5=F ..-., 6=G --., 7=H ....
REQ-006 Port: led  output  1  Morse output, high while a symbol is keyed.
REQ-007 Port: busy  output  1  high in every state except IDLE.
REQ-008 Port: done  output  1  one-cycle pulse marking completion of a letter.
REQ-009 Port: state  output  3  current state encoding, for LEDR debug display.

Function
REQ-010 The block SHALL hold an internal letter table: length (1-4 symbols) and a 4-bit pattern, MSB-first, 0=dot, 1=dash, left-justified.
REQ-011 States and encodings SHALL be IDLE=0, SYM=1, GAP=2, TAIL=3, DONE=4; encodings 5-7 SHALL go to IDLE on the next edge.
REQ-012 IDLE: led=0, busy=0, done=0; start=1 SHALL latch letter's pattern and length, enter SYM on the next edge, and load the unit timer.
REQ-013 start SHALL be ignored in every state other than IDLE; letter changes after acceptance SHALL have no effect.
REQ-014 SYM: led=1 for exactly UNIT_CYCLES cycles for a dot, or exactly 3*UNIT_CYCLES cycles for a dash.
REQ-015 SYM exit with symbols remaining SHALL go to GAP; GAP holds led=0 for exactly UNIT_CYCLES cycles, shifts the pattern left by one, then returns to SYM.
REQ-016 SYM exit on the last symbol SHALL go to DONE, or to TAIL when MORSE_TRAILING_GAP_EN is defined.
REQ-017 DONE SHALL last exactly one cycle with done=1 and led=0, then return to IDLE.
REQ-018 A start asserted in the DONE cycle SHALL be ignored; the earliest accepted restart is the first IDLE cycle.
REQ-019 The timer SHALL be wide enough to count 3*UNIT_CYCLES without overflow (at least 30 bits).
REQ-020 With UNIT_CYCLES=1, a dot SHALL be exactly one cycle of led=1.
REQ-021 Letter time, from the start-accept edge to the done pulse, SHALL be: sum of symbol on-times + (length-1)*UNIT_CYCLES (+3*UNIT_CYCLES with the tail) + 1 cycle.

Reset
REQ-022 While Reset=1 at an edge, the block SHALL set state=IDLE, led=0, busy=0, done=0, and clear the timer, pattern and count.
REQ-023 Reset asserted mid-letter SHALL abort the letter on the next edge; no done pulse SHALL be issued for the aborted letter.
REQ-024 Reset and start asserted together SHALL leave the block in IDLE, with the start discarded.

Configuration
REQ-025 Macro MORSE_TRAILING_GAP_EN defined: after the last symbol the block SHALL enter TAIL, hold led=0 for 3*UNIT_CYCLES cycles, then enter DONE.
REQ-026 MORSE_TRAILING_GAP_EN undefined: TAIL SHALL be unreachable and the last SYM SHALL go directly to DONE; encoding 3 SHALL then be treated as illegal (go to IDLE).

Verification (UNIT_CYCLES=4; start accepted at cycle 0)
REQ-027 Reset held 2 cycles, then released -> led=0, busy=0, done=0, state=0.
REQ-028 letter=4 (E), no macro -> led=1 cycles 1-4; done=1 at cycle 5; state=0 at cycle 6.
REQ-029 letter=0 (A), no macro -> led=1 cycles 1-4, led=0 cycles 5-8, led=1 cycles 9-20; done at cycle 21.
REQ-030 letter=4 with MORSE_TRAILING_GAP_EN -> led=1 cycles 1-4, led=0 with state=3 cycles 5-16; done at cycle 17.
REQ-031 letter=7 (H), start re-pulsed at cycle 6 with letter=0 -> second start ignored; H runs to completion with done at cycle 29.
REQ-032 letter=1 (B), Reset pulsed at cycle 10 -> state=0, led=0 from cycle 11; no done pulse within the next 40 cycles.
